// File: rtl/readout_stream.sv
// readout_stream: waits for a cell readout cycle to start and finish, then scans the
// whole snapshot RAM and emits every populated entry as an (index, data, valid) beat.
// Latency 2 cycles per address, 1 address per cycle; no backpressure, every beat must be taken.
// Ports: i_clk, i_reset (sync, active-high); i_readout_active / i_readout_valid start a scan;
//        o_readout_address -> i_readout_data / i_readout_present (1-cycle RAM read latency);
//        o_packet_index / o_packet_data / o_packet_valid carry the emitted beats.
module readout_stream #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 50
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_readout_active,
  input  logic                  i_readout_valid,
  input  logic                  i_readout_present,
  output logic [ADDR_WIDTH-1:0] o_readout_address,
  input  logic [DATA_WIDTH-1:0] i_readout_data,
  output logic [ADDR_WIDTH-1:0] o_packet_index,
  output logic [DATA_WIDTH-1:0] o_packet_data,
  output logic                  o_packet_valid
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ACTIVE     = 2'd1,
    WAIT_VALID = 2'd2,
    STREAM     = 2'd3
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  // Scan counter needs room for 2^ADDR_WIDTH issue cycles plus 2 drain cycles.
  localparam int SW = ADDR_WIDTH + 2;
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SCAN_ADDRS = SW'(2 ** ADDR_WIDTH);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(2 ** ADDR_WIDTH + 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_active_d;
  logic [TW-1:0]         r_to_cnt;
  logic [SW-1:0]         r_scan_cnt;
  logic                  r_rd_vld;
  logic [ADDR_WIDTH-1:0] r_rd_idx;
  logic                  w_active_rise;
  logic                  w_issue;

  // A read is issued only during the first 2^ADDR_WIDTH STREAM cycles; the last two
  // STREAM cycles only drain the RAM and output registers.
  always_comb begin
    w_active_rise     = i_readout_active & ~r_active_d;
    w_issue           = (r_state == STREAM) && (r_scan_cnt < SCAN_ADDRS);
    o_readout_address = w_issue ? r_scan_cnt[ADDR_WIDTH-1:0] : '0;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        // Only a fresh edge of readoutActive arms the block; a lingering valid level does not.
        if (w_active_rise) w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (i_readout_valid)        w_state_nxt = STREAM;
        else if (!i_readout_active) w_state_nxt = WAIT_VALID;
      end
      WAIT_VALID: begin
        if (i_readout_valid)            w_state_nxt = STREAM;
        else if (r_to_cnt == TO_LAST)   w_state_nxt = IDLE;
      end
      STREAM: begin
        if (r_scan_cnt == SCAN_LAST) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_active_d     <= 1'b0;
      r_to_cnt       <= '0;
      r_scan_cnt     <= '0;
      r_rd_vld       <= 1'b0;
      r_rd_idx       <= '0;
      o_packet_valid <= 1'b0;
      o_packet_index <= '0;
      o_packet_data  <= '0;
    end else begin
      r_active_d <= i_readout_active;
      // Both counters sit at zero outside their own state, so entry needs no explicit clear.
      r_to_cnt   <= (r_state == WAIT_VALID) ? r_to_cnt + 1'b1 : '0;
      r_scan_cnt <= (r_state == STREAM && w_state_nxt == STREAM) ? r_scan_cnt + 1'b1 : '0;
      // Stage 1 remembers which address the RAM is answering this cycle.
      r_rd_vld   <= w_issue;
      r_rd_idx   <= o_readout_address;
      // Stage 2 registers the beat; absent entries never strobe.
      o_packet_valid <= r_rd_vld & i_readout_present;
      if (r_rd_vld && i_readout_present) begin
        o_packet_index <= r_rd_idx;
        o_packet_data  <= i_readout_data;
      end
    end
  end

endmodule

// File: tb/tb_readout_stream.sv
module tb_readout_stream;
  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int TO    = 50;
  localparam int NADDR = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          active = 1'b0;
  logic          valid = 1'b0;
  logic          rd_pres = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic [AW-1:0] addr;
  logic [AW-1:0] pk_idx;
  logic [DW-1:0] pk_dat;
  logic          pk_vld;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int addr_viol = 0;

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] dat;
    int            cyc;
  } beat_t;

  typedef struct {
    int            lo;
    int            hi;
    int            step;
    logic [DW-1:0] base;
    int            exp_cnt;
    int            len;
    int            voff;
    int            rst_at;
  } vec_t;

  beat_t         got[$];
  logic [DW-1:0] mem [NADDR];

  readout_stream #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_readout_active  (active),
    .i_readout_valid   (valid),
    .i_readout_present (rd_pres),
    .o_readout_address (addr),
    .i_readout_data    (rd_data),
    .o_packet_index    (pk_idx),
    .o_packet_data     (pk_dat),
    .o_packet_valid    (pk_vld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Snapshot RAM: one-cycle read latency, present flag = nonzero data.
  always @(posedge clk) begin
    rd_data <= mem[addr];
    rd_pres <= (mem[addr] != '0);
  end

  always @(negedge clk) begin
    if (pk_vld === 1'b1) got.push_back('{pk_idx, pk_dat, cyc});
    if (dut.r_state != 2'd3 && addr != '0) addr_viol++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill_mem(input int lo, input int hi, input int step, input logic [DW-1:0] base);
    for (int i = 0; i < NADDR; i++) mem[i] = '0;
    for (int i = lo; i <= hi; i += step) mem[i] = base | DW'(i);
  endtask

  task automatic fill_random();
    logic [DW-1:0] d;
    for (int i = 0; i < NADDR; i++) begin
      d = $urandom;
      if (d == '0) d = 1;
      mem[i] = ($urandom_range(0, 1) == 1) ? d : '0;
    end
  endtask

  // Drives one active/valid sequence: active high for len cycles, valid raised voff cycles
  // after the fall (negative = while active is still high), optional reset rst_at cycles
  // into STREAM, and valid kept high 20 cycles past the expected return to IDLE.
  task automatic do_scan(input string tag, input int len, input int voff, input int rst_at,
                         input int exp_cnt, input bit jitter);
    int    c0;
    int    s;
    int    last;
    int    n;
    bit    scan;
    beat_t exp_q[$];
    got.delete();
    @(posedge clk); #1;
    c0   = cyc;
    scan = (voff <= TO);
    s    = c0 + len + voff + 1;
    if (!scan)            last = c0 + len + TO + 1;
    else if (rst_at >= 0) last = s + rst_at + 1;
    else                  last = s + NADDR + 2;
    for (int t = 0; c0 + t < last + 20; t++) begin
      active = (t < len);
      if (jitter && scan && (c0 + t > s + 2) && (c0 + t < s + NADDR - 60))
        active = ($urandom_range(0, 1) == 1);
      valid = (t >= len + voff);
      reset = (rst_at >= 0) && (c0 + t == s + rst_at);
      @(negedge clk);
      if (c0 + t == last - 1)
        chk({tag, ":state_before_idle"}, 64'(dut.r_state), scan ? 64'd3 : 64'd2);
      if (c0 + t == last) begin
        chk({tag, ":state_idle"}, 64'(dut.r_state), 64'd0);
        chk({tag, ":valid_low_at_idle"}, 64'(pk_vld), 64'd0);
      end
      @(posedge clk); #1;
    end
    active = 1'b0;
    valid  = 1'b0;
    reset  = 1'b0;
    chk({tag, ":no_rescan_state"}, 64'(dut.r_state), 64'd0);
    // Reference: every populated address in ascending order, each beat 2 cycles after its
    // address is issued; a reset at STREAM cycle rst_at cuts off beats due after it.
    if (scan)
      for (int i = 0; i < NADDR; i++)
        if (mem[i] != '0 && (rst_at < 0 || i <= rst_at - 2))
          exp_q.push_back('{AW'(i), mem[i], s + 2 + i});
    chk({tag, ":beat_count"}, 64'(got.size()), 64'(exp_q.size()));
    if (exp_cnt >= 0) chk({tag, ":beat_count_const"}, 64'(got.size()), 64'(exp_cnt));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int k = 0; k < n; k++)
      chk({tag, ":beat{idx,data,latency}"},
          {7'd0, got[k].idx, got[k].dat, 16'(got[k].cyc - s)},
          {7'd0, exp_q[k].idx, exp_q[k].dat, 16'(exp_q[k].cyc - s)});
  endtask

  vec_t tbl[10];

  initial begin
    for (int i = 0; i < NADDR; i++) mem[i] = '0;
    tbl[0] = '{32'h20, 32'h5F, 1, 32'h0000_0800, 64,  10, 1,      -1};
    tbl[1] = '{32'h20, 32'h5F, 1, 32'h0000_0800, 64,  10, -4,     -1};
    tbl[2] = '{0,      511,    1, 32'h1000_0000, 512, 3,  TO,     -1};
    tbl[3] = '{0,      511,    2, 32'h0000_A000, 256, 5,  2,      -1};
    tbl[4] = '{511,    511,    1, 32'hDEAD_0000, 1,   1,  1,      -1};
    tbl[5] = '{0,      0,      1, 32'h0000_0001, 1,   4,  0,      -1};
    tbl[6] = '{32'h20, 32'h5F, 1, 32'h0000_0800, 0,   10, TO + 1, -1};
    tbl[7] = '{32'h20, 32'h5F, 1, 32'h0000_0800, 0,   10, 1000,   -1};
    tbl[8] = '{32'h20, 32'h5F, 1, 32'h0000_0800, 15,  10, 1,      32'h30};
    tbl[9] = '{32'h20, 32'h5F, 1, 32'h0000_0800, 64,  10, 1,      -1};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset:state",   64'(dut.r_state), 64'd0);
    chk("reset:address", 64'(addr),        64'd0);
    chk("reset:index",   64'(pk_idx),      64'd0);
    chk("reset:data",    64'(pk_dat),      64'd0);
    chk("reset:valid",   64'(pk_vld),      64'd0);

    for (int v = 0; v < 10; v++) begin
      fill_mem(tbl[v].lo, tbl[v].hi, tbl[v].step, tbl[v].base);
      do_scan($sformatf("vec%0d", v), tbl[v].len, tbl[v].voff, tbl[v].rst_at,
              tbl[v].exp_cnt, 1'b0);
    end

    // Timeout, then a late reset must leave the block idle.
    do_scan("timeout2", 10, 1000, -1, 0, 1'b0);
    repeat (80) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("late_reset:state", 64'(dut.r_state), 64'd0);

    // Random snapshots, random valid timing, readoutActive toggling during STREAM.
    for (int r = 0; r < 4; r++) begin
      int len;
      int voff;
      len  = $urandom_range(1, 15);
      voff = $urandom_range(0, TO + len - 1) - (len - 1);
      fill_random();
      do_scan($sformatf("rand%0d", r), len, voff, -1, -1, 1'b1);
    end

    chk("address_zero_outside_stream", 64'(addr_viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/readout_stream.md
# readout_stream

Converts a completed cell-readout snapshot held in an external dual-port RAM into a stream of indexed data words. It waits for a readout cycle to start and finish, then scans the whole RAM address space. Every populated entry is emitted as a (packetIndex, packetData, packetValid) beat for the downstream packet builder. If a readout cycle never completes, the block times out and returns to idle.

## Interface
- ADDR_WIDTH, 9: RAM address width and packetIndex width.
- DATA_WIDTH, 32: RAM word width and packetData width.
- TIMEOUT, 50: cycles to wait for readoutValid after readoutActive falls.
- clk  input  1  sole clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high; forces IDLE and clears all outputs.
- readoutActive  input  1  high while the cell readout cycle is in progress.
- readoutValid  input  1  high when the RAM holds a complete, valid snapshot; level, may stay high.
- readoutPresent  input  1  RAM entry flag returned alongside readoutData (entry populated).
- readoutAddress  output  ADDR_WIDTH  RAM read address.
- readoutData  input  DATA_WIDTH  RAM read data, valid one cycle after readoutAddress.
- packetIndex  output  ADDR_WIDTH  RAM address of the emitted word.
- packetData  output  DATA_WIDTH  emitted word.
- packetValid  output  1  one-cycle strobe per emitted word.

## Operation
- State register `state`, encoded IDLE=0, ACTIVE=1, WAIT_VALID=2, STREAM=3.
- IDLE:
  - Detects a rising edge of readoutActive, using a registered copy of the previous value.
  - On that edge, goes to ACTIVE.
  - A readoutValid level alone never starts a scan.
- ACTIVE:
  - readoutValid high goes to STREAM.
  - Otherwise, readoutActive low goes to WAIT_VALID with the timeout counter cleared.
- WAIT_VALID:
  - readoutValid high goes to STREAM.
  - Otherwise the counter increments each cycle.
  - When the counter reaches TIMEOUT-1, goes to IDLE (link timeout) without emitting anything.
- STREAM:
  - readoutAddress starts at 0 and increments by 1 per cycle up to 2^ADDR_WIDTH-1.
  - After issuing the last address, the block drains the 2-cycle pipeline and then returns to IDLE.
- Emission rule: a word is emitted only when readoutPresent is high in its data cycle.
  - packetIndex equals the address that was read.
  - packetData equals readoutData for that address.
  - Absent entries produce no strobe.
- Indices are emitted strictly ascending, with no duplicates and no wrap-around within a scan.
- readoutAddress holds 0 outside STREAM.
- reset at any time, including mid-scan, does the following:
  - aborts to IDLE;
  - clears the address, counter and pipeline;
  - drops packetValid on the next cycle;
  - discards any partially streamed snapshot.
- A new rising edge of readoutActive during STREAM is ignored.

## Timing
- Reset values:
  - state = IDLE;
  - readoutAddress = 0;
  - packetIndex = 0;
  - packetData = 0;
  - packetValid = 0.
- Rising edge of readoutActive sampled at edge N: state = ACTIVE from cycle N+1.
- RAM read latency is 1 cycle: address issued in cycle k, readoutData/readoutPresent valid in cycle k+1.
- Outputs are registered: the beat for address k appears in cycle k+2 relative to the first STREAM cycle. Latency is 2 cycles per address, throughput is 1 address per cycle.
- Full scan occupies 2^ADDR_WIDTH + 2 cycles, then state = IDLE.
- Timeout: with readoutValid low, IDLE is reached TIMEOUT cycles after readoutActive is sampled low.
- Simultaneous readoutValid and readoutActive high in ACTIVE: STREAM takes priority.

## Test plan
- Reset is asserted, then released:
  - all outputs are 0 and state = 0.
- Link timeout: readoutActive high for 10 cycles, low, readoutValid held 0:
  - no packetValid ever;
  - state returns to 0 50 cycles after the fall.
  - A reset 80 cycles later leaves state at 0.
- Successful readout, with 0x20–0x5F loaded with 0x0820–0x085F and all other locations 0 (present = data≠0):
  - stimulus: readoutActive high for 10 cycles, low, then readoutValid high one cycle later;
  - exactly 64 strobes, packetIndex 0x20..0x5F ascending, packetData = 0x0800|index;
  - state returns to 0.
- readoutValid held high after the scan:
  - no second scan until the next readoutActive rising edge.
- Reset mid-STREAM (e.g. at address 0x30):
  - packetValid is 0 from the next cycle;
  - state = 0;
  - a subsequent active/valid sequence streams the full 64 entries again.
- readoutValid asserted while readoutActive is still high:
  - the scan starts immediately;
  - the same 64 correct beats are emitted.
